mux_pipe_n: RTL and testbench
=============================

# mux_pipe_n

Parametrised, registered N-way 32-bit-class datapath selector, successor to the fixed 5-input combinational selectors in the datapath. Picks one of `N_IN` packed input words, either by explicit select code or by round-robin over a channel mask. It registers the result behind a one-deep valid/ready stage, so multi-cycle control can stall the consumer without losing the selected word.

## Interface

**Parameters**
- `WIDTH`, default 32: data word width in bits.
- `N_IN`, default 8: number of input channels, 2..64.
- `SEL_W`, default `$clog2(N_IN)`: select code width. Must not be overridden below `$clog2(N_IN)`.

**Ports** (one clock; reset is synchronous and active-low)
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `reset_n`, in, 1: synchronous active-low reset, sampled on `clk` rising edge.
- `mode`, in, 1: 0 = direct select via `signal`; 1 = round-robin over `chan_mask`.
- `signal`, in, `SEL_W`: channel code used in mode 0.
- `chan_mask`, in, `N_IN`: eligible channels in mode 1; bit i enables channel i.
- `data_in`, in, `N_IN*WIDTH`: packed inputs; channel i is `data_in[i*WIDTH +: WIDTH]`.
- `in_valid`, in, 1: request to capture a selection this cycle.
- `in_ready`, out, 1: stage can accept this cycle.
- `data_Out`, out, `WIDTH`: registered selected word.
- `out_valid`, out, 1: `data_Out` holds an unconsumed word.
- `out_ready`, in, 1: consumer takes `data_Out` this cycle.
- `out_sel`, out, `SEL_W`: channel index that produced `data_Out`.
- `sel_err`, out, 1: registered flag; the captured mode-0 code was ≥ `N_IN`.

## Operation

- **Ready rule:** `in_ready = !out_valid || out_ready`. It is combinational and independent of `mode` and `chan_mask`.
- **Capture condition:** `accept = in_valid && in_ready && (mode==0 || chan_mask != 0)`.
- **Mode 0:**
  - On accept, `data_Out` ← channel `signal`, `out_sel` ← `signal`, `sel_err` ← 0.
  - If `signal` ≥ `N_IN`: `data_Out` ← 0, `out_sel` ← `signal`, `sel_err` ← 1. `out_valid` is still set.
- **Mode 1:**
  - Internal pointer `rr_ptr` (`SEL_W` bits).
  - Selected channel = first set bit of `chan_mask` scanning upward from `rr_ptr`, wrapping from `N_IN-1` to 0.
  - On accept: `data_Out` ← that channel, `out_sel` ← its index, `sel_err` ← 0, and `rr_ptr` ← (index+1) mod `N_IN`.
  - `rr_ptr` changes only on a mode-1 accept. It does not move in mode 0.
- **`chan_mask` == 0 in mode 1:** no capture. If `out_ready` is high, a pending word is consumed normally and `out_valid` drops. `rr_ptr` is unchanged.
- **Output handshake:**
  - `out_valid` sets on accept.
  - `out_valid` clears on `out_valid && out_ready` without a same-cycle accept.
  - Consume and accept in the same cycle: the new word replaces the old one and `out_valid` stays 1.
- **Hold:** while `out_valid && !out_ready`, `data_Out`, `out_sel` and `sel_err` are stable and `in_ready` is 0.
- **Reset:** when `reset_n`==0 at an edge, `out_valid`, `data_Out`, `out_sel`, `sel_err` and `rr_ptr` all become 0. Reset overrides any simultaneous accept or consume.
- **Mode switching:** `mode` may change on any cycle. It affects only the next accept.

## Timing

- **Latency:** 1 cycle from accept edge to `data_Out`/`out_valid` visible.
- **Throughput:** one word per cycle when `out_ready` is held high.
- **Combinational paths:** `in_ready` depends combinationally only on `out_valid` and `out_ready`. There is no combinational path from `data_in`, `signal` or `chan_mask` to any output.
- **Reset-mid-operation:** a word held under backpressure is discarded by reset. The first edge after `reset_n` returns to 1 may accept normally, with `rr_ptr` = 0.

## Test plan

1. **Mode 0 sweep.** Stimulus: `N_IN`=8, `data_in` channel i = 0xA000_0000+i, `out_ready`=1; apply `signal` 0..7 on consecutive cycles with `in_valid`=1. Required: `data_Out` = 0xA000_0000..0xA000_0007 one cycle later each, `out_sel` tracks, `out_valid` continuously 1.
2. **Out-of-range code.** Stimulus: `N_IN`=5, `SEL_W`=3, `signal`=6, accept. Required: next cycle `data_Out`=0, `out_sel`=6, `sel_err`=1, `out_valid`=1. A following accept with `signal`=4 clears `sel_err` and gives channel 4.
3. **Round-robin with wrap.** Stimulus: mode 1, `chan_mask`=8'b1001_0010, continuous `in_valid`, `out_ready`=1. Required: `out_sel` sequence 1, 4, 7, 1, 4, with `rr_ptr` wrapping after channel 7.
4. **Backpressure.** Stimulus: accept channel 3 (0x1234_5678), then hold `out_ready`=0 for 4 cycles with `in_valid`=1 and `signal`=5. Required: `in_ready`=0 during the hold, `data_Out` stays 0x1234_5678 and `out_valid` stays 1. On the cycle `out_ready` rises, the channel-5 word is accepted and appears one cycle later with `out_valid` never dropping.
5. **Empty mask.** Stimulus: mode 1, `chan_mask`=0, `in_valid`=1, `out_ready`=1, starting with a word pending. Required: the pending word is consumed, `out_valid` falls to 0 and stays 0, and `rr_ptr` is unchanged (next non-zero mask resumes from the old pointer).
6. **Reset mid-hold.** Stimulus: `out_valid`=1 under `out_ready`=0; drive `reset_n`=0 for one edge together with `in_valid`=1. Required: after that edge all outputs and `rr_ptr` are 0. The next edge with `reset_n`=1 accepts normally.

Source files
------------

// File: rtl/mux_pipe_n.sv
// Registered N-way word selector (direct code or round-robin over a channel mask).
// Latency 1 cycle; one-deep output stage: in_ready = !out_valid || out_ready, word held while stalled.
module mux_pipe_n #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      signal,
  input  logic [N_IN-1:0]       chan_mask,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_Out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [2*N_IN-1:0] mask_dbl;
  logic [2*N_IN-1:0] mask_rot;
  logic              rr_found;
  logic [31:0]       rr_pos;
  logic [SEL_W-1:0]  rr_idx;
  logic [31:0]       rr_inc;
  logic [SEL_W-1:0]  rr_next;
  logic [SEL_W-1:0]  pick_idx;
  logic [WIDTH-1:0]  pick_word;
  logic              sel_oob;
  logic              accept;

  assign in_ready = !out_valid_q || out_ready;

  // Rotate the mask so bit 0 is the channel at rr_ptr; the lowest set bit of
  // the rotated view is the next eligible channel in wrap-around order.
  always_comb begin
    mask_dbl = {chan_mask, chan_mask};
    mask_rot = mask_dbl >> rr_ptr_q;
    rr_found = 1'b0;
    rr_pos   = '0;
    for (int j = N_IN - 1; j >= 0; j--) begin
      if (mask_rot[j]) begin
        rr_found = 1'b1;
        rr_pos   = 32'(rr_ptr_q) + 32'(unsigned'(j));
      end
    end
    if (rr_pos >= 32'(N_IN)) begin
      rr_pos = rr_pos - 32'(N_IN);
    end
    rr_idx = rr_pos[SEL_W-1:0];
    rr_inc = 32'(rr_idx) + 32'd1;
    if (rr_inc >= 32'(N_IN)) begin
      rr_inc = '0;
    end
    rr_next = rr_inc[SEL_W-1:0];
  end

  // An out-of-range code matches no channel, so the word falls through as zero.
  always_comb begin
    pick_idx  = mode ? rr_idx : signal;
    sel_oob   = !mode && (32'(signal) >= 32'(N_IN));
    pick_word = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pick_idx == SEL_W'(i)) begin
        pick_word = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = in_valid && in_ready && (!mode || rr_found);

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sel_d       = sel_q;
    err_d       = err_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = pick_word;
      sel_d       = pick_idx;
      err_d       = sel_oob;
      if (mode) begin
        rr_ptr_d = rr_next;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_Out  = data_q;
  assign out_sel   = sel_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: an 8-channel instance for the main flows and a 5-channel one for out-of-range codes.
module tb_mux_pipe_n;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 8-channel instance
  logic         mode8, iv8, ordy8, irdy8, vld8, err8;
  logic [2:0]   sig8, osel8;
  logic [7:0]   mask8;
  logic [255:0] din8;
  logic [31:0]  dout8;

  mux_pipe_n #(.WIDTH(32), .N_IN(8)) u8 (
    .clk(clk), .reset_n(reset_n), .mode(mode8), .signal(sig8), .chan_mask(mask8),
    .data_in(din8), .in_valid(iv8), .in_ready(irdy8), .data_Out(dout8),
    .out_valid(vld8), .out_ready(ordy8), .out_sel(osel8), .sel_err(err8)
  );

  // 5-channel instance with a 3-bit code, so codes 5..7 are out of range
  logic         mode5, iv5, ordy5, irdy5, vld5, err5;
  logic [2:0]   sig5, osel5;
  logic [4:0]   mask5;
  logic [159:0] din5;
  logic [31:0]  dout5;

  mux_pipe_n #(.WIDTH(32), .N_IN(5), .SEL_W(3)) u5 (
    .clk(clk), .reset_n(reset_n), .mode(mode5), .signal(sig5), .chan_mask(mask5),
    .data_in(din5), .in_valid(iv5), .in_ready(irdy5), .data_Out(dout5),
    .out_valid(vld5), .out_ready(ordy5), .out_sel(osel5), .sel_err(err5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mode;
    logic [2:0]  sig;
    logic [7:0]  mask;
    logic        iv;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_vld;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [2:0]  exp_sel;
    logic [2:0]  exp_rr;
  } vec_t;

  vec_t vt[$];

  localparam logic [7:0] M = 8'b1001_0010;

  function automatic vec_t mk(logic mode, logic [2:0] sig, logic [7:0] mask, logic iv, logic ordy,
                              logic exp_rdy, logic exp_vld, logic chk_dat, logic [31:0] exp_dat,
                              logic [2:0] exp_sel, logic [2:0] exp_rr);
    vec_t v;
    v.mode = mode; v.sig = sig; v.mask = mask; v.iv = iv; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.chk_dat = chk_dat;
    v.exp_dat = exp_dat; v.exp_sel = exp_sel; v.exp_rr = exp_rr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the 8-channel inputs, check in_ready before the edge, then step past the edge.
  task automatic cyc8(input string name, input logic mode, input logic [2:0] sig, input logic [7:0] mask,
                      input logic iv, input logic ordy, input logic exp_rdy);
    mode8 = mode; sig8 = sig; mask8 = mask; iv8 = iv; ordy8 = ordy;
    #1;
    chk({name, ".in_ready"}, irdy8, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic out8(input string name, input logic vld, input logic [31:0] dat, input logic [2:0] sel,
                      input logic err, input logic [2:0] rr);
    chk({name, ".out_valid"}, vld8, vld);
    chk({name, ".data_Out"}, dout8, dat);
    chk({name, ".out_sel"}, osel8, sel);
    chk({name, ".sel_err"}, err8, err);
    chk({name, ".rr_ptr"}, u8.rr_ptr_q, rr);
  endtask

  task automatic cyc5(input logic [2:0] sig, input logic iv);
    mode5 = 1'b0; sig5 = sig; iv5 = iv; ordy5 = 1'b1; mask5 = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    mode8 = 0; sig8 = 0; mask8 = 0; iv8 = 0; ordy8 = 0;
    mode5 = 0; sig5 = 0; mask5 = 0; iv5 = 0; ordy5 = 0;
    for (int i = 0; i < 8; i++) din8[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) din5[i*32 +: 32] = 32'hB000_0000 + 32'(i);

    // Reset state
    iv8 = 1'b1; ordy8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out8("reset", 1'b0, 32'h0, 3'd0, 1'b0, 3'd0);
    chk("reset.u5.out_valid", vld5, 1'b0);
    chk("reset.u5.data_Out", dout5, 32'h0);
    chk("reset.u5.sel_err", err5, 1'b0);
    iv8 = 1'b0;
    reset_n = 1'b1;

    // Out-of-range code on the 5-channel instance
    cyc5(3'd6, 1'b1);
    chk("oob6.out_valid", vld5, 1'b1);
    chk("oob6.data_Out", dout5, 32'h0);
    chk("oob6.out_sel", osel5, 3'd6);
    chk("oob6.sel_err", err5, 1'b1);
    cyc5(3'd4, 1'b1);
    chk("ch4.data_Out", dout5, 32'hB000_0004);
    chk("ch4.out_sel", osel5, 3'd4);
    chk("ch4.sel_err", err5, 1'b0);
    cyc5(3'd5, 1'b1);
    chk("oob5.data_Out", dout5, 32'h0);
    chk("oob5.out_sel", osel5, 3'd5);
    chk("oob5.sel_err", err5, 1'b1);
    cyc5(3'd0, 1'b0);
    chk("drain5.out_valid", vld5, 1'b0);

    // Table: mode-0 sweep, round-robin wrap, empty mask, pointer resume, pointer frozen in mode 0
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 3'(i), 8'h00, 1, 1, 1, 1, 1, 32'hA000_0000 + 32'(i), 3'(i), 3'd0));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0001, 3'd1, 3'd2));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0004, 3'd4, 3'd5));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0007, 3'd7, 3'd0));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0001, 3'd1, 3'd2));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0004, 3'd4, 3'd5));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 3'd0, 3'd5));
    vt.push_back(mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 32'h0, 3'd0, 3'd5));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0007, 3'd7, 3'd0));
    vt.push_back(mk(0, 2, M, 1, 1, 1, 1, 1, 32'hA000_0002, 3'd2, 3'd0));
    vt.push_back(mk(1, 0, M, 1, 1, 1, 1, 1, 32'hA000_0001, 3'd1, 3'd2));

    for (int n = 0; n < vt.size(); n++) begin
      string nm;
      nm = $sformatf("vec%0d", n);
      cyc8(nm, vt[n].mode, vt[n].sig, vt[n].mask, vt[n].iv, vt[n].ordy, vt[n].exp_rdy);
      chk({nm, ".out_valid"}, vld8, vt[n].exp_vld);
      if (vt[n].chk_dat) begin
        chk({nm, ".data_Out"}, dout8, vt[n].exp_dat);
        chk({nm, ".out_sel"}, osel8, vt[n].exp_sel);
        chk({nm, ".sel_err"}, err8, 1'b0);
      end
      chk({nm, ".rr_ptr"}, u8.rr_ptr_q, vt[n].exp_rr);
    end

    // Backpressure: channel 3 held for 4 stalled cycles, channel 5 taken as out_ready rises
    din8[3*32 +: 32] = 32'h1234_5678;
    cyc8("bp_load", 0, 3'd3, M, 1, 1, 1);
    out8("bp_load", 1'b1, 32'h1234_5678, 3'd3, 1'b0, 3'd2);
    for (int k = 0; k < 4; k++) begin
      cyc8($sformatf("bp_hold%0d", k), 0, 3'd5, M, 1, 0, 0);
      out8($sformatf("bp_hold%0d", k), 1'b1, 32'h1234_5678, 3'd3, 1'b0, 3'd2);
    end
    cyc8("bp_release", 0, 3'd5, M, 1, 1, 1);
    out8("bp_release", 1'b1, 32'hA000_0005, 3'd5, 1'b0, 3'd2);

    // Reset while a word is held under backpressure
    cyc8("rst_hold", 0, 3'd2, M, 1, 0, 0);
    out8("rst_hold", 1'b1, 32'hA000_0005, 3'd5, 1'b0, 3'd2);
    reset_n = 1'b0;
    cyc8("rst_edge", 0, 3'd6, M, 1, 0, 0);
    out8("rst_edge", 1'b0, 32'h0, 3'd0, 1'b0, 3'd0);
    reset_n = 1'b1;
    cyc8("rst_after", 0, 3'd6, M, 1, 1, 1);
    out8("rst_after", 1'b1, 32'hA000_0006, 3'd6, 1'b0, 3'd0);
    cyc8("rst_rr", 1, 3'd0, M, 1, 1, 1);
    out8("rst_rr", 1'b1, 32'hA000_0001, 3'd1, 1'b0, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
